// File: rtl/gray_pkg.sv
// Shared definitions for the Gray encode/decode paths: occupancy states and
// the binary-to-Gray mapping used by both sides.
package gray_pkg;

  localparam int unsigned GRAY_MAX_WIDTH = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_out_buf.sv
// Two-entry valid/ready output buffer. Entry 0 is always the head; the
// occupancy FSM also produces registered valid/full flags.
module gray_out_buf
  import gray_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_full
);

  occ_e         r_state;
  logic [W-1:0] r_d0;
  logic [W-1:0] r_d1;
  logic         r_valid;
  logic         r_full;
  logic         w_pop;

  assign w_pop   = r_valid && i_ready;
  assign o_data  = r_d0;
  assign o_valid = r_valid;
  assign o_full  = r_full;

  // A push while FULL cannot occur: the producer side is gated by o_full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= OCC_EMPTY;
      r_d0    <= '0;
      r_d1    <= '0;
      r_valid <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      case (r_state)
        OCC_EMPTY: begin
          if (i_push) begin
            r_d0    <= i_data;
            r_valid <= 1'b1;
            r_state <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (i_push && w_pop) begin
            r_d0 <= i_data;
          end else if (i_push) begin
            r_d1    <= i_data;
            r_full  <= 1'b1;
            r_state <= OCC_FULL;
          end else if (w_pop) begin
            r_valid <= 1'b0;
            r_state <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (w_pop) begin
            r_d0    <= r_d1;
            r_full  <= 1'b0;
            r_state <= OCC_ONE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_full  <= 1'b0;
          r_state <= OCC_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/gray_encoder_tx.sv
// Binary-to-Gray transmitter: direct input or internal up/down counter source,
// encoded at push time into a 2-entry buffer. Optional GRAY_PARITY_EN adds gray_par_o.
module gray_encoder_tx
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bin_i,
  input  logic             bin_valid_i,
  output logic             bin_ready_o,
  input  logic             mode_i,
  input  logic             cnt_en_i,
  input  logic             cnt_up_i,
  output logic [WIDTH-1:0] gray_o,
  output logic             gray_valid_o,
  input  logic             gray_ready_i,
  output logic [WIDTH-1:0] count_o
`ifdef GRAY_PARITY_EN
  ,
  output logic             gray_par_o
`endif
);

`ifdef GRAY_PARITY_EN
  localparam int unsigned BufW = WIDTH + 1;
`else
  localparam int unsigned BufW = WIDTH;
`endif

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] w_gray;
  logic [BufW-1:0]  w_buf_in;
  logic [BufW-1:0]  w_buf_out;
  logic             w_full;
  logic             w_push_dir;
  logic             w_push_cnt;
  logic             w_push;

  // Ready depends only on registered occupancy, never on gray_ready_i.
  assign bin_ready_o = !w_full && !mode_i && !rst;
  assign w_push_dir  = !mode_i && bin_valid_i && bin_ready_o;
  assign w_push_cnt  = mode_i && cnt_en_i && !w_full;
  assign w_push      = w_push_dir || w_push_cnt;

  assign w_bin  = mode_i ? r_count : bin_i;
  assign w_gray = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(w_bin)));

`ifdef GRAY_PARITY_EN
  assign w_buf_in   = {^w_gray, w_gray};
  assign gray_par_o = w_buf_out[WIDTH];
`else
  assign w_buf_in   = w_gray;
`endif
  assign gray_o  = w_buf_out[WIDTH-1:0];
  assign count_o = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_push_cnt) begin
      r_count <= cnt_up_i ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
    end
  end

  gray_out_buf #(
    .W (BufW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_buf_in),
    .i_ready (gray_ready_i),
    .o_data  (w_buf_out),
    .o_valid (gray_valid_o),
    .o_full  (w_full)
  );

endmodule
